// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: FSM state encoding and counter width helper
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, STOP = 2'd3} state_t;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-flop synchroniser, optional debounce (DEBOUNCE_EN), armed rising-edge event
module btn_conditioner
  import stopwatch_pkg::*;
`ifdef DEBOUNCE_EN
  #(parameter int DB = 1)
`endif
  (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);
  logic s0, s1, lvl, prev, armed;
  logic [1:0] fill;
  // synchronise the pin; fill marks when s1 carries a real pin sample rather than the reset value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      fill <= '0;
    end else begin
      s0 <= btn;
      s1 <= s0;
      fill <= {fill[0], 1'b1};
    end
`ifdef DEBOUNCE_EN
  localparam int W = cw(DB);
  logic [W-1:0] cnt;
  logic acc;
  // accept a new level only after DB consecutive samples disagree with the current one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      acc <= 1'b0;
    end else if (s1 == acc) cnt <= '0;
    else if (cnt == W'(DB - 1)) begin
      acc <= s1;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
  assign lvl = acc;
`else
  assign lvl = s1;
`endif
  // arm after a genuine low sample so a button held through reset never fires
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      armed <= 1'b0;
      prev <= 1'b0;
      evt <= 1'b0;
    end else begin
      armed <= armed | (fill[1] & ~s1);
      prev <= lvl;
      evt <= armed & lvl & ~prev;
    end
endmodule

// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer: button conditioning, tick divider and run/stop/lap/clear FSM; DEBOUNCE_EN adds debounce
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
`ifdef DEBOUNCE_EN
  , parameter int DEBOUNCE_MS = 10
`endif
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       tick_100hz,
  output logic       cnt_tick,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_freeze,
  output logic [1:0] state
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW = cw(DIV);
`ifdef DEBOUNCE_EN
  localparam int DB = int'(longint'(DEBOUNCE_MS) * CLK_HZ / 1000);
`endif
  logic [DW-1:0] div_cnt;
  logic pre_tick, ev_start, ev_lap, ev_clear, clr_n, ld_n;
  state_t st, ns;
  btn_conditioner `ifdef DEBOUNCE_EN #(.DB(DB)) `endif u_start (.clk(clk_100mhz), .rst(rst), .btn(btn_start), .evt(ev_start));
  btn_conditioner `ifdef DEBOUNCE_EN #(.DB(DB)) `endif u_lap (.clk(clk_100mhz), .rst(rst), .btn(btn_lap), .evt(ev_lap));
  btn_conditioner `ifdef DEBOUNCE_EN #(.DB(DB)) `endif u_clear (.clk(clk_100mhz), .rst(rst), .btn(btn_clear), .evt(ev_clear));
  assign pre_tick = div_cnt == DW'(DIV - 2);
  // free-running divider; tick is registered one count early so it aligns with the registered FSM outputs
  always_ff @(posedge clk_100mhz or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      tick_100hz <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
      tick_100hz <= pre_tick;
    end
  // next state and pulses, priority clear > start > lap; ignored events do not block lower ones
  always_comb begin
    ns = st;
    clr_n = 1'b0;
    ld_n = 1'b0;
    case (st)
      IDLE, STOP: if (ev_clear) begin
        ns = IDLE;
        clr_n = 1'b1;
      end else if (ev_start) ns = RUN;
      RUN: if (ev_start) ns = STOP;
      else if (ev_lap) begin
        ns = LAP;
        ld_n = 1'b1;
      end
      default: ns = ev_start ? STOP : (ev_lap ? RUN : LAP);
    endcase
  end
  // registered state and outputs
  always_ff @(posedge clk_100mhz or posedge rst)
    if (rst) begin
      st <= IDLE;
      cnt_tick <= 1'b0;
      cnt_clr <= 1'b0;
      lap_load <= 1'b0;
      disp_freeze <= 1'b0;
    end else begin
      st <= ns;
      cnt_clr <= clr_n;
      lap_load <= ld_n;
      disp_freeze <= ns == LAP;
      cnt_tick <= pre_tick & (ns == RUN | ns == LAP);
    end
  assign state = st;
endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb_stopwatch_sequencer: table vectors, corner sequences and random stimulus against a sample-history model
module tb_stopwatch_sequencer;
  localparam int DIV = 10;
`ifdef DEBOUNCE_EN
  localparam int DBV = 4;
`else
  localparam int DBV = 0;
`endif
  logic clk_100mhz = 1'b0, rst = 1'b1, btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic tick_100hz, cnt_tick, cnt_clr, lap_load, disp_freeze;
  logic [1:0] state;
  logic [6:0] outs, mexp = '0;
  int npass = 0, ntot = 0, e = 0, ms = 0;
  bit smp [3][4096];
  bit acc [3][4096];
  bit low [3][4096];
  typedef struct {int st; logic [2:0] b; logic [1:0] xs; logic xclr; logic xld; logic xfrz;} vec_t;
  vec_t tbl [16];

  always #5 clk_100mhz = ~clk_100mhz;
  assign outs = {tick_100hz, cnt_tick, cnt_clr, lap_load, disp_freeze, state};

  stopwatch_sequencer #(.CLK_HZ(1000), .TICK_HZ(100)
`ifdef DEBOUNCE_EN
    , .DEBOUNCE_MS(4)
`endif
  ) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .tick_100hz(tick_100hz), .cnt_tick(cnt_tick), .cnt_clr(cnt_clr), .lap_load(lap_load),
    .disp_freeze(disp_freeze), .state(state)
  );

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s at edge %0d: got %b expected %b", nm, e, act, exp);
  endtask

  // b = {clear, lap, start}; accepted level follows the sampled pin (or a unanimous DBV-sample window)
  task automatic model_edge(input logic [2:0] b);
    logic [2:0] ev;
    logic clr, ld, tk, a1, a0;
    int ns;
    for (int i = 0; i < 3; i++) begin
      smp[i][e] = b[i];
      low[i][e] = low[i][e-1] | !b[i];
      if (DBV == 0) acc[i][e] = (e >= 2) ? smp[i][e-1] : 1'b0;
      else if (e - 1 - DBV >= 1) begin
        a1 = 1'b1;
        a0 = 1'b1;
        for (int j = e - 1 - DBV; j <= e - 2; j++) begin
          a1 = a1 & smp[i][j];
          a0 = a0 & !smp[i][j];
        end
        acc[i][e] = a1 ? 1'b1 : (a0 ? 1'b0 : acc[i][e-1]);
      end else acc[i][e] = acc[i][e-1];
      ev[i] = (e >= 4) && acc[i][e-2] && !acc[i][e-3] && low[i][e-4];
    end
    ns = ms;
    clr = 1'b0;
    ld = 1'b0;
    if (ev[2] && (ms == 0 || ms == 3)) begin
      ns = 0;
      clr = 1'b1;
    end else if (ev[0]) ns = (ms == 1 || ms == 2) ? 3 : 1;
    else if (ev[1] && ms == 1) begin
      ns = 2;
      ld = 1'b1;
    end else if (ev[1] && ms == 2) ns = 1;
    tk = (e % DIV) == DIV - 1;
    mexp = {tk, tk && (ns == 1 || ns == 2), clr, ld, ns == 2, 2'(ns)};
    ms = ns;
  endtask

  task automatic cyc(input logic [2:0] b);
    {btn_clear, btn_lap, btn_start} = b;
    @(posedge clk_100mhz);
    e++;
    model_edge(b);
    @(negedge clk_100mhz);
    chk("cycle", outs, mexp);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(3'b000);
  endtask

  task automatic do_reset(input logic [2:0] b);
    {btn_clear, btn_lap, btn_start} = b;
    rst = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    chk("in_reset", outs, 7'd0);
    rst = 1'b0;
    e = 0;
    ms = 0;
    mexp = '0;
    for (int i = 0; i < 3; i++) begin
      acc[i][0] = 1'b0;
      low[i][0] = 1'b0;
    end
  endtask

  // hold the buttons, then wait until the FSM has acted on them
  task automatic press(input logic [2:0] b);
    int act;
    act = e + 4 + DBV;
    repeat (DBV + 2) cyc(b);
    while (e < act) cyc(3'b000);
  endtask

  initial begin
    logic [2:0] cur;
    int f;
    tbl[0]  = '{0, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{0, 3'b100, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{0, 3'b010, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{0, 3'b101, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1, 3'b001, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1, 3'b010, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1, 3'b100, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1, 3'b101, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1, 3'b011, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2, 3'b010, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2, 3'b001, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2, 3'b100, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{3, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3, 3'b100, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{3, 3'b010, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{3, 3'b101, 2'd0, 1'b1, 1'b0, 1'b0};
    do_reset(3'b000);
    idle(35);
    for (int k = 0; k < 16; k++) begin
      do_reset(3'b000);
      idle(3);
      if (tbl[k].st != 0) begin
        press(3'b001);
        idle(DBV + 3);
      end
      if (tbl[k].st == 2) begin
        press(3'b010);
        idle(DBV + 3);
      end
      if (tbl[k].st == 3) begin
        press(3'b001);
        idle(DBV + 3);
      end
      chk("setup_state", {5'd0, state}, {5'd0, 2'(tbl[k].st)});
      press(tbl[k].b);
      chk("table", {3'd0, state, cnt_clr, lap_load, disp_freeze},
          {3'd0, tbl[k].xs, tbl[k].xclr, tbl[k].xld, tbl[k].xfrz});
    end
    do_reset(3'b000);
    idle(3);
    press(3'b001);
    idle(12);
    btn_start = 1'b1;
    @(posedge clk_100mhz);
    #2 rst = 1'b1;
    #1 chk("async_reset", outs, 7'd0);
    do_reset(3'b001);
    repeat (30) cyc(3'b001);
    chk("held_no_event", {5'd0, state}, 7'd0);
    idle(DBV + 4);
    press(3'b001);
    chk("after_held", {5'd0, state}, 7'd1);
`ifdef DEBOUNCE_EN
    do_reset(3'b000);
    idle(5);
    cyc(3'b001);
    cyc(3'b001);
    cyc(3'b000);
    cyc(3'b000);
    f = e + 1;
    while (e < f + DBV + 2) cyc(3'b001);
    chk("db_before", {5'd0, state}, 7'd0);
    cyc(3'b001);
    chk("db_event", {5'd0, state}, 7'd1);
    repeat (12) cyc(3'b001);
    chk("db_single", {5'd0, state}, 7'd1);
`endif
    do_reset(3'b000);
    idle(5);
    cur = 3'b000;
    repeat (1500) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
      cyc(cur);
    end
    f = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
